// File: rtl/multi_edge_pulse.sv
// multi_edge_pulse: per-channel two-flop synchroniser, debounce filter and
// registered edge pulse generator. Defining MULTI_EDGE_PULSE_REPEAT_EN adds
// hold-to-repeat pulses on held channels (EDGE_MODE 0 and 2 only).
module multi_edge_pulse #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out_pulse,
    output logic [WIDTH-1:0] level,
    output logic             any_pulse
);

    localparam int CNT_RAW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Parameter sanity is checked while elaborating, so a bad build never exists.
    if (WIDTH < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_size
        $error("multi_edge_pulse: WIDTH and DEBOUNCE_CYCLES must be >= 1");
    end
    if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
        $error("multi_edge_pulse: EDGE_MODE must be 0, 1 or 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("multi_edge_pulse: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    // Picks which accepted level changes become pulses.
    function automatic logic [WIDTH-1:0] edge_select(input logic [WIDTH-1:0] rise,
                                                     input logic [WIDTH-1:0] fall);
        case (EDGE_MODE)
            0:       edge_select = rise;
            1:       edge_select = fall;
            default: edge_select = rise | fall;
        endcase
    endfunction

    logic [WIDTH-1:0] sync1_p0;
    logic [WIDTH-1:0] s2_p1;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] rep_fire;

    // ---- stage p0/p1: two-flop synchroniser for the asynchronous inputs ----
    // Synchroniser flops, cleared by reset so a held input re-presses afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_p0 <= '0;
            s2_p1    <= '0;
        end else begin
            sync1_p0 <= in;
            s2_p1    <= sync1_p0;
        end
    end

    // ---- stage p2: debounce; a change is accepted on its DEBOUNCE_CYCLES-th mismatch ----
    // Flags channels whose synchronised value has differed long enough to be accepted.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (s2_p1[i] != level[i]) && (cnt[i] == CNT_LAST);
        end
        edge_hit = edge_select(accept & ~level, accept & level);
    end

    // Mismatch-run counter and debounced level; any short run is simply forgotten.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2_p1[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    level[i] <= s2_p1[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef MULTI_EDGE_PULSE_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PER_LAST = REP_W'(REPEAT_PERIOD - 1);
    localparam bit REPEAT_ALLOWED = (EDGE_MODE != 1);

    logic [REP_W-1:0] rep_cnt [WIDTH];
    logic [WIDTH-1:0] rep_phase;

    // A held channel fires after the initial delay, then once per period.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rep_fire[i] = REPEAT_ALLOWED && level[i] && !accept[i] &&
                          (rep_cnt[i] == (rep_phase[i] ? PER_LAST : DLY_LAST));
        end
    end

    // Repeat timer: restarts on every rising acceptance and stops when the level drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_phase <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!level[i] || accept[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (rep_fire[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b1;
                end else if (REPEAT_ALLOWED) begin
                    rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
                end
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

    // ---- stage p3: registered pulse output ----
    // One-cycle pulse per accepted edge or repeat; coincident sources merge into one.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_pulse <= '0;
        end else begin
            out_pulse <= edge_hit | rep_fire;
        end
    end

    assign any_pulse = |out_pulse;

endmodule
